aes_sub_bytes_encrypt: RTL and testbench

- Sequential forward AES SubBytes engine for the encrypt datapath; the encryption-direction counterpart of the inverse S-box used on the decrypt side.
- Takes a 128-bit state over a valid/ready handshake and substitutes all 16 bytes with the FIPS-197 forward S-box.
- Computes each S-box value arithmetically: GF(2^8) inverse x^254 by square-and-multiply, then the affine transform. No 256-entry table.
- Sits between AddRoundKey and ShiftRows in the round pipeline.

---
 rtl/aes_sub_bytes_encrypt.sv | 152 +++++++++++++++
 tb/tb_aes_sub_bytes_encrypt.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_encrypt.sv
// Forward AES SubBytes engine: per byte, x^254 by square-and-multiply in GF(2^8), then the affine map.
// Optional feature: define AES_SUB_BYTES_ENCRYPT_ABORT_EN to add a synchronous abort input.
module aes_sub_bytes_encrypt #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
`ifdef AES_SUB_BYTES_ENCRYPT_ABORT_EN
    ,
    input  logic         abort
`endif
);
    localparam int GROUPS = 16 / LANES;
    localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] LAST_GROUP = GW'(GROUPS - 1);
    localparam logic [3:0] LAST_STEP = 4'd12;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("aes_sub_bytes_encrypt: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} fsm_t;

    fsm_t            state_reg, state_next;
    logic [GW-1:0]   group_reg;
    logic [3:0]      step_reg;
    logic [7:0]      data_reg   [16];
    logic [7:0]      result_reg [16];
    logic [3:0]      lane_idx   [LANES];
    logic [7:0]      sbox_val   [LANES];
    logic            abort_hit;
    logic            calc_go;
    logic            last_step;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1 (shift-and-add).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
        end
        return r ^ 8'h63;
    endfunction

`ifdef AES_SUB_BYTES_ENCRYPT_ABORT_EN
    assign abort_hit = abort && (state_reg != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign calc_go   = (state_reg == CALC) && !abort_hit;
    assign last_step = (step_reg == LAST_STEP);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] acc_reg;
            logic [7:0] x;
            logic [7:0] op_a;
            logic [7:0] op_b;
            logic [7:0] prod;

            assign lane_idx[gi] = 4'(int'(group_reg) * LANES + gi);
            assign x            = data_reg[lane_idx[gi]];
            // Even steps square (step 0 squares x itself), odd steps multiply by x.
            assign op_a         = (step_reg == 4'd0) ? x : acc_reg;
            assign op_b         = step_reg[0] ? x : op_a;
            assign prod         = gf_mul(op_a, op_b);
            assign sbox_val[gi] = affine(prod);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (calc_go) begin
                    acc_reg <= prod;
                end
            end
        end

        for (gi = 0; gi < 16; gi++) begin : g_out
            assign state_out[127 - 8*gi -: 8] = result_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = CALC;
            CALC: if (last_step && group_reg == LAST_GROUP) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_hit) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            group_reg <= '0;
            step_reg  <= '0;
            for (int k = 0; k < 16; k++) begin
                data_reg[k]   <= '0;
                result_reg[k] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && in_valid) begin
                for (int k = 0; k < 16; k++) begin
                    data_reg[k] <= state_in[127 - 8*k -: 8];
                end
                group_reg <= '0;
                step_reg  <= '0;
            end else if (calc_go) begin
                if (last_step) begin
                    for (int l = 0; l < LANES; l++) begin
                        result_reg[lane_idx[l]] <= sbox_val[l];
                    end
                    step_reg <= '0;
                    if (group_reg != LAST_GROUP) group_reg <= group_reg + GW'(1);
                end else begin
                    step_reg <= step_reg + 4'd1;
                end
            end
        end
    end

    assign in_ready  = rst_n && (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == CALC) || (state_reg == DONE);

endmodule

// File: tb/tb_aes_sub_bytes_encrypt.sv
// Scoreboard bench for aes_sub_bytes_encrypt: table-based reference S-box, latency and handshake checks.
// Also runs LANES=1/2/8/16 instances side by side for latency and result checks.
module tb_aes_sub_bytes_encrypt;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic         abort     = 1'b0;
    logic [127:0] state_in  = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] state_out;

    logic         x_in_valid  = 1'b0;
    logic         x_out_ready = 1'b0;
    logic [127:0] x_state_in  = '0;
    logic         x_in_ready  [4];
    logic         x_out_valid [4];
    logic         x_busy      [4];
    logic [127:0] x_state_out [4];

    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_txn = 0;
    logic [127:0] exp_q [$];
    logic [127:0] mon_exp;
    logic [2047:0] sbox_bits;

    aes_sub_bytes_encrypt #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
`ifdef AES_SUB_BYTES_ENCRYPT_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_x
            aes_sub_bytes_encrypt #(.LANES(gi == 0 ? 1 : gi == 1 ? 2 : gi == 2 ? 8 : 16)) u_x (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (x_in_valid),
                .in_ready  (x_in_ready[gi]),
                .state_in  (x_state_in),
                .out_valid (x_out_valid[gi]),
                .out_ready (x_out_ready),
                .state_out (x_state_out[gi]),
                .busy      (x_busy[gi])
`ifdef AES_SUB_BYTES_ENCRYPT_ABORT_EN
                ,
                .abort     (1'b0)
`endif
            );
        end
    endgenerate

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = s[127 - 8*k -: 8];
            r[127 - 8*k -: 8] = sbox_bits[2047 - 8*int'(b) -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output-side scoreboard: one line per completed transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", state_out, '0);
            end else begin
                mon_exp = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: state_out=%h expected=%h", n_txn, state_out, mon_exp);
                check_val("result", state_out, mon_exp);
            end
        end
    end

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        check_val(tag, 128'(n), 128'd52);
    endtask

    task automatic drain_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("out_valid_after_xfer", 128'(out_valid), 128'd0);
        check_val("in_ready_after_xfer", 128'(in_ready), 128'd1);
    endtask

    task automatic run_txn(input logic [127:0] data, input logic [127:0] exp, input int hold);
        logic [127:0] snap;
        check_val("in_ready_idle", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        state_in = data;
        exp_q.push_back(exp);
        tick();
        in_valid = 1'b0;
        state_in = rand128();
        wait_out("latency");
        snap = state_out;
        for (int h = 0; h < hold; h++) begin
            tick();
            state_in = rand128();
            if (h == 0 || h == hold - 1) begin
                check_val("bp_out_valid", 128'(out_valid), 128'd1);
                check_val("bp_stable", state_out, snap);
                check_val("bp_in_ready", 128'(in_ready), 128'd0);
            end
        end
        drain_out();
    endtask

    task automatic x_txn(input logic [127:0] data);
        int  lat  [4];
        bit  seen [4];
        int  n;
        int  lanes;
        for (int i = 0; i < 4; i++) begin
            lat[i]  = -1;
            seen[i] = 1'b0;
        end
        x_in_valid = 1'b1;
        x_state_in = data;
        tick();
        x_in_valid = 1'b0;
        n = 0;
        while (n < 300 && !(seen[0] && seen[1] && seen[2] && seen[3])) begin
            tick();
            n++;
            for (int i = 0; i < 4; i++) begin
                if (!seen[i] && x_out_valid[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = n;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            lanes = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 16;
            $display("lanes %0d: latency=%0d state_out=%h", lanes, lat[i], x_state_out[i]);
            check_val($sformatf("x_latency_l%0d", lanes), 128'(lat[i]), 128'(208 / lanes));
            check_val($sformatf("x_result_l%0d", lanes), x_state_out[i], ref_sub(data));
        end
        x_out_ready = 1'b1;
        tick();
        x_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("x_in_ready_after", 128'(x_in_ready[i]), 128'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, b, corner;
        sbox_bits = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        corner = 128'h000153ff_00000000_00000000_00000000;

        #1 rst_n = 1'b0;
        #2;
        check_val("rst_in_ready", 128'(in_ready), 128'd0);
        check_val("rst_out_valid", 128'(out_valid), 128'd0);
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_state_out", state_out, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_val("rel_in_ready", 128'(in_ready), 128'd1);

        run_txn(128'h00112233445566778899aabbccddeeff, 128'h638293c31bfc33f5c4eeacea4bc12816, 0);
        run_txn(corner, 128'h637ced16_63636363_63636363_63636363, 20);
        for (int r = 0; r < 3; r++) begin
            a = rand128();
            run_txn(a, ref_sub(a), r);
        end

        // New state held on in_valid during CALC must wait for IDLE.
        a = rand128();
        b = rand128();
        in_valid = 1'b1;
        state_in = a;
        exp_q.push_back(ref_sub(a));
        tick();
        state_in = b;
        wait_out("latency_held_valid");
        check_val("done_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("held_idle_in_ready", 128'(in_ready), 128'd1);
        exp_q.push_back(ref_sub(b));
        tick();
        in_valid = 1'b0;
        wait_out("latency_second");
        drain_out();

        // Reset while processing step 5 of group 1.
        in_valid = 1'b1;
        state_in = rand128();
        tick();
        in_valid = 1'b0;
        repeat (18) tick();
        check_val("mid_busy", 128'(busy), 128'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check_val("mid_rst_busy", 128'(busy), 128'd0);
        check_val("mid_rst_in_ready", 128'(in_ready), 128'd0);
        check_val("mid_rst_state_out", state_out, '0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        run_txn('0, {16{8'h63}}, 0);

        x_txn(corner);
        x_txn(rand128());

`ifdef AES_SUB_BYTES_ENCRYPT_ABORT_EN
        // Abort in CALC: back to IDLE, never completes.
        in_valid = 1'b1;
        state_in = rand128();
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_calc_busy", 128'(busy), 128'd0);
        check_val("abort_calc_in_ready", 128'(in_ready), 128'd1);
        begin
            bit rose;
            rose = 1'b0;
            repeat (60) begin
                tick();
                if (out_valid) rose = 1'b1;
            end
            check_val("abort_no_out_valid", 128'(rose), 128'd0);
        end

        // Abort together with out_ready in DONE: no transfer.
        in_valid = 1'b1;
        state_in = rand128();
        tick();
        in_valid = 1'b0;
        wait_out("latency_abort_done");
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        out_ready = 1'b0;
        check_val("abort_done_out_valid", 128'(out_valid), 128'd0);
        check_val("abort_done_in_ready", 128'(in_ready), 128'd1);

        // Abort alone in DONE.
        in_valid = 1'b1;
        state_in = rand128();
        tick();
        in_valid = 1'b0;
        wait_out("latency_abort_only");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_only_out_valid", 128'(out_valid), 128'd0);

        // Abort in IDLE does not block acceptance.
        a = rand128();
        abort = 1'b1;
        in_valid = 1'b1;
        state_in = a;
        exp_q.push_back(ref_sub(a));
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        check_val("abort_idle_busy", 128'(busy), 128'd1);
        wait_out("latency_abort_idle");
        drain_out();
`endif

        check_val("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
